dma_controller: RTL

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dma_controller.sv
// Byte-wide memory-to-memory DMA engine behind a 6-byte io register window.
// Optional constant-fill mode is compiled in with DMA_FILL_EN.
module dma_controller #(
  parameter logic [7:0] DMA_ADDRESS = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic [7:0]  address,
  input  logic        w_en,
  input  logic        r_en,
  output logic [7:0]  dout,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [15:0] m_address,
  output logic [7:0]  m_dout,
  input  logic [7:0]  m_din,
  output logic        m_w_en,
  output logic        m_r_en,
  output logic        done_flag,
  input  logic        done_flag_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0] src, dst;
  logic [7:0]  len, data;
  logic [7:0]  offs, rd_mux;
  logic        aborted, fill;
  logic        sel, busy, ctrl_wr;
  logic        start, abort;
  logic        rd_fire, cap_fire, wr_fire;

  assign offs    = address - DMA_ADDRESS;
  assign sel     = offs < 8'd6;
  assign busy    = state != S_IDLE;
  assign ctrl_wr = w_en && sel && offs == 8'd5;
  assign start   = ctrl_wr && din[0] && !busy;
  assign abort   = ctrl_wr && din[7] && busy;

  // An abort write kills the strobes in the same cycle
  assign rd_fire  = state == S_RD && bus_grant && !abort;
  assign cap_fire = state == S_CAP && bus_grant && !abort;
  assign wr_fire  = state == S_WR && bus_grant && !abort;

`ifdef DMA_FILL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= 1'b0;
    end else if (start) begin
      fill <= din[1];
    end
  end
`else
  assign fill = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (len == 8'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_grant) begin
          state_nx = fill ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (bus_grant) begin
          state_nx = S_CAP;
        end
      end
      S_CAP: begin
        if (bus_grant) begin
          state_nx = S_WR;
        end
      end
      S_WR: begin
        if (bus_grant) begin
          if (len == 8'd1) begin
            state_nx = S_DONE;
          end else begin
            state_nx = fill ? S_WR : S_RD;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nx = S_IDLE;
    end
  end

  always_comb begin
    bus_req   = state inside {S_REQ, S_RD, S_CAP, S_WR};
    m_r_en    = rd_fire;
    m_w_en    = wr_fire;
    m_address = 16'h0000;
    m_dout    = 8'h00;
    if (rd_fire) begin
      m_address = src;
    end
    if (wr_fire) begin
      m_address = dst;
      m_dout    = fill ? src[7:0] : data;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (1'b1)
      (offs == 8'd0): rd_mux = src[7:0];
      (offs == 8'd1): rd_mux = src[15:8];
      (offs == 8'd2): rd_mux = dst[7:0];
      (offs == 8'd3): rd_mux = dst[15:8];
      (offs == 8'd4): rd_mux = len;
      (offs == 8'd5): rd_mux = {done_flag, 4'b0000, fill, aborted, busy};
      default:        rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src       <= 16'h0000;
      dst       <= 16'h0000;
      len       <= 8'h00;
      data      <= 8'h00;
      aborted   <= 1'b0;
      done_flag <= 1'b0;
      dout      <= 8'h00;
    end else begin
      state <= state_nx;
      dout  <= (r_en && sel) ? rd_mux : 8'h00;
      if (w_en && sel && !busy) begin
        case (offs)
          8'd0:    src[7:0]  <= din;
          8'd1:    src[15:8] <= din;
          8'd2:    dst[7:0]  <= din;
          8'd3:    dst[15:8] <= din;
          8'd4:    len       <= din;
          default: ;
        endcase
      end
      if (cap_fire) begin
        data <= m_din;
      end
      if (wr_fire) begin
        if (!fill) begin
          src <= src + 16'd1;
        end
        dst <= dst + 16'd1;
        len <= len - 8'd1;
      end
      if (start) begin
        aborted <= 1'b0;
      end else if (abort) begin
        aborted <= 1'b1;
      end
      // Setting the flag takes priority over a simultaneous clear
      if (state == S_DONE && !abort) begin
        done_flag <= 1'b1;
      end else if (done_flag_clr) begin
        done_flag <= 1'b0;
      end
    end
  end

endmodule
